lpc_order_select: RTL and testbench
===================================

// Module: lpc_order_select
// PURPOSE
//  Parametrised successor to the fixed 12-order FIR error bank. Takes residual streams from NUM_ORDERS
//  parallel LPC predictors, each with its own valid. Sums |residual| per order over one block of
//  BLOCK_SIZE samples, then runs a sequential argmin scan. Reports the best order (1-based) and its total
//  error with a one-cycle done pulse. Sits between the FIR bank and the subframe encoder's order decision.
// PARAMETERS
//  NUM_ORDERS  12    number of predictor orders (order m = index m-1), 2..32
//  RES_W       16    signed residual width
//  ACC_W       28    unsigned accumulator width; saturating
//  BLOCK_SIZE  4096  residuals per order per block, 1..2**CNT_W-1
//  CNT_W       13    per-order residual counter width
// PORTS
//  iClock      in   1                 rising-edge clock
//  iReset      in   1                 asynchronous, active-high reset
//  iEnable     in   1                 global enable; low freezes all state (outputs hold)
//  iStart      in   1                 pulse: clear accumulators/counters, enter ACCUM
//  iResValid   in   NUM_ORDERS        bit m-1: residual of order m valid this cycle
//  iResidual   in   NUM_ORDERS*RES_W  packed signed residuals, order m at [m*RES_W-1 -: RES_W]
//  oBestOrder  out  5                 winning order, 1..NUM_ORDERS
//  oBestError  out  ACC_W             total |residual| of winning order
//  oBusy       out  1                 high in ACCUM or SCAN
//  oDone       out  1                 one-cycle pulse when oBestOrder/oBestError become valid
// BEHAVIOUR
//  - Reset (async): state IDLE, all accumulators/counters 0, oBestOrder=1, oBestError=0, oBusy=0, oDone=0.
//  - All sequential updates are gated by iEnable=1. iStart is sampled only when iEnable=1.
//  - FSM IDLE -> ACCUM on iStart. In ACCUM, order m accepts a residual when iResValid[m-1]=1 and
//    cnt[m-1] < BLOCK_SIZE. On accept, cnt increments and acc += |res|.
//  - |res| is an RES_W-bit unsigned magnitude, so -2**(RES_W-1) maps to 2**(RES_W-1) with no overflow.
//  - Valids arriving after an order's cnt reaches BLOCK_SIZE are ignored. Valids in IDLE/SCAN/DONE are ignored.
//  - acc saturates at 2**ACC_W-1 and never wraps.
//  - ACCUM -> SCAN on the edge after every cnt equals BLOCK_SIZE.
//  - SCAN lasts NUM_ORDERS cycles and examines one order per cycle, ascending from order 1.
//    Order 1 initialises best. A later order replaces best only if its acc < best (strict).
//    Ties therefore go to the lowest order.
//  - SCAN -> DONE after the last order. In DONE: oBestOrder/oBestError update, oDone=1 for exactly one
//    cycle, then IDLE. Outputs hold until the next DONE.
//  - Latency: oDone is high NUM_ORDERS+2 rising edges after the edge that accepted the final residual.
//  - oBusy=1 in ACCUM and SCAN, 0 in IDLE and DONE.
//  - iStart in ACCUM or SCAN aborts the block: clear accumulators/counters, restart ACCUM, no oDone.
//    iStart in DONE: oDone still pulses this cycle, and the FSM enters ACCUM next.
//  - iReset asserted mid-block aborts immediately to reset values.
// CONFIGURATION
//  WARMUP_EXCLUDE_EN defined: the first m accepted residuals of order m (FLAC warm-up samples) increment
//    cnt but are not added to acc.
//  WARMUP_EXCLUDE_EN undefined: every accepted residual is added. This matches the legacy bank.
// TESTING
//  T1 NUM_ORDERS=4, BLOCK_SIZE=8; orders 1..4 feed constant residuals 5,-3,4,7 each cycle
//     -> accs 40,24,32,56; oBestOrder=2, oBestError=24; oDone single-cycle, 6 edges after last accept.
//  T2 Orders 2 and 3 both total 24, order 1 = 30 -> oBestOrder=2 (tie to lowest).
//  T3 Staggered valids: order 4 valids lag 3 cycles, plus extra valids after BLOCK_SIZE
//     -> same result as T1, extras ignored, SCAN waits for order 4.
//  T4 RES_W=16, ACC_W=18, residual -32768 on all samples -> abs 32768 counted, acc saturates at 262143.
//  T5 iStart at sample 5 of ACCUM, then a clean block -> no oDone for the aborted block, result matches clean block.
//     Separately, iReset mid-SCAN -> outputs return to 1/0, oBusy=0.
//  T6 WARMUP_EXCLUDE_EN defined, BLOCK_SIZE=8, residual 10 on all orders -> order m acc = 10*(8-m);
//     oBestOrder=NUM_ORDERS. Undefined -> all accs 80, oBestOrder=1.

Source files
------------

// File: rtl/lpc_order_select.sv
// Per-order |residual| accumulation over one block, then a sequential argmin scan picking the best LPC order.
// Build option: define WARMUP_EXCLUDE_EN to keep the first m residuals of order m out of its error sum.
module lpc_order_select #(
  parameter int NUM_ORDERS = 12,
  parameter int RES_W      = 16,
  parameter int ACC_W      = 28,
  parameter int BLOCK_SIZE = 4096,
  parameter int CNT_W      = 13
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic                        iEnable,
  input  logic                        iStart,
  input  logic [NUM_ORDERS-1:0]       iResValid,
  input  logic [NUM_ORDERS*RES_W-1:0] iResidual,
  output logic [4:0]                  oBestOrder,
  output logic [ACC_W-1:0]            oBestError,
  output logic                        oBusy,
  output logic                        oDone
);

  localparam int IDX_W = (NUM_ORDERS > 1) ? $clog2(NUM_ORDERS) : 1;
  localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_SIZE);
  localparam logic [ACC_W-1:0] ACC_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [NUM_ORDERS-1:0][ACC_W-1:0] acc_vec;
  logic [NUM_ORDERS-1:0]            full;

  logic [IDX_W-1:0] scan_idx_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [ACC_W-1:0] best_err_q;
  logic [ACC_W-1:0] scan_acc;
  logic             scan_last;
  logic [4:0]       out_order_q;
  logic [ACC_W-1:0] out_error_q;
  logic             done_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ORDERS; gi++) begin : g_ord
      logic [ACC_W-1:0] acc_q;
      logic [CNT_W-1:0] cnt_q;
      logic [RES_W-1:0] res;
      logic [RES_W-1:0] mag;
      logic [ACC_W:0]   sum;
      logic             accept;
      logic             add_en;

      // Unsigned magnitude: the most negative residual maps cleanly to 2**(RES_W-1).
      assign res    = iResidual[gi*RES_W +: RES_W];
      assign mag    = res[RES_W-1] ? (~res + RES_W'(1)) : res;
      assign sum    = {1'b0, acc_q} + (ACC_W+1)'(mag);
      assign accept = (state_q == S_ACCUM) && iResValid[gi] && (cnt_q < BLOCK_CNT);
`ifdef WARMUP_EXCLUDE_EN
      assign add_en = (cnt_q > CNT_W'(gi));
`else
      assign add_en = 1'b1;
`endif
      assign full[gi]    = (cnt_q == BLOCK_CNT);
      assign acc_vec[gi] = acc_q;

      always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else if (iEnable) begin
          if (iStart) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (add_en) acc_q <= sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
          end
        end
      end
    end
  endgenerate

  assign scan_acc  = acc_vec[scan_idx_q];
  assign scan_last = (scan_idx_q == IDX_W'(NUM_ORDERS - 1));

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state_q <= S_IDLE;
    else if (iEnable) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (iStart) begin
      state_d = S_ACCUM;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_ACCUM: if (&full) state_d = S_SCAN;
        S_SCAN:  if (scan_last) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    oBusy = (state_q == S_ACCUM) || (state_q == S_SCAN);
  end

  // Strict less-than keeps ties on the lowest order; order 32 encodes as 0 in the 5-bit output.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      scan_idx_q  <= '0;
      best_idx_q  <= '0;
      best_err_q  <= '0;
      out_order_q <= 5'd1;
      out_error_q <= '0;
      done_q      <= 1'b0;
    end else if (iEnable) begin
      done_q <= 1'b0;
      unique case (state_q)
        S_SCAN: begin
          scan_idx_q <= scan_idx_q + IDX_W'(1);
          if ((scan_idx_q == '0) || (scan_acc < best_err_q)) begin
            best_err_q <= scan_acc;
            best_idx_q <= scan_idx_q;
          end
        end
        S_DONE: begin
          out_order_q <= 5'(best_idx_q) + 5'd1;
          out_error_q <= best_err_q;
          done_q      <= 1'b1;
        end
        default: scan_idx_q <= '0;
      endcase
    end
  end

  assign oBestOrder = out_order_q;
  assign oBestError = out_error_q;
  assign oDone      = done_q;

endmodule

// File: tb/tb_lpc_order_select.sv
// Scoreboard bench for lpc_order_select: two instances (wide and narrow accumulator) share one stimulus stream.
module tb_lpc_order_select;
  localparam int N    = 4;
  localparam int BS   = 8;
  localparam int RW   = 16;
  localparam int AW_M = 28;
  localparam int AW_S = 18;
  localparam int CW   = 13;
  localparam int MAXC = 16;
`ifdef WARMUP_EXCLUDE_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  order;
    logic [27:0] err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en, start;
  logic [N-1:0]    val;
  logic [N*RW-1:0] res;
  logic [4:0]      order_m, order_s;
  logic [AW_M-1:0] err_m;
  logic [AW_S-1:0] err_s;
  logic            busy_m, busy_s, done_m, done_s;

  lpc_order_select #(.NUM_ORDERS(N), .RES_W(RW), .ACC_W(AW_M), .BLOCK_SIZE(BS), .CNT_W(CW)) dut_m (
    .iClock(clk), .iReset(rst), .iEnable(en), .iStart(start), .iResValid(val), .iResidual(res),
    .oBestOrder(order_m), .oBestError(err_m), .oBusy(busy_m), .oDone(done_m));

  lpc_order_select #(.NUM_ORDERS(N), .RES_W(RW), .ACC_W(AW_S), .BLOCK_SIZE(BS), .CNT_W(CW)) dut_s (
    .iClock(clk), .iReset(rst), .iEnable(en), .iStart(start), .iResValid(val), .iResidual(res),
    .oBestOrder(order_s), .oBestError(err_s), .oBusy(busy_s), .oDone(done_s));

  exp_t q_m[$];
  exp_t q_s[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   accept_cyc = 0;
  logic prev_done_m = 1'b0;

  int stim_res[MAXC][N];
  bit stim_val[MAXC][N];
  bit stim_en[MAXC];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every oDone pops one expectation per instance.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done_m === 1'b1) begin
      total++;
      if (done_m !== 1'b0) begin bad++; $display("FAIL done_pulse_width: oDone=%b required 0", done_m); end
    end
    prev_done_m = done_m;
    if (done_m === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      total++;
      if (q_m.size() == 0) begin
        bad++; $display("FAIL unexpected_done_main: oDone=1 required no result pending");
      end else begin
        e = q_m.pop_front();
        $display("result main: order=%0d error=%0d (want %0d/%0d)", order_m, err_m, e.order, e.err);
        if (order_m !== e.order) begin bad++; $display("FAIL best_order_main: got %0d required %0d", order_m, e.order); end
        total++;
        if (err_m !== e.err) begin bad++; $display("FAIL best_error_main: got %0d required %0d", err_m, e.err); end
      end
    end
    if (done_s === 1'b1) begin
      total++;
      if (q_s.size() == 0) begin
        bad++; $display("FAIL unexpected_done_sat: oDone=1 required no result pending");
      end else begin
        e = q_s.pop_front();
        if (order_s !== e.order) begin bad++; $display("FAIL best_order_sat: got %0d required %0d", order_s, e.order); end
        total++;
        if ({10'b0, err_s} !== e.err) begin bad++; $display("FAIL best_error_sat: got %0d required %0d", err_s, e.err); end
      end
    end
  end

  function automatic exp_t model(input int nc, input int aw);
    longint acc[N];
    int     cnt[N];
    longint maxv;
    longint mag;
    int     best;
    exp_t   e;
    maxv = (longint'(1) << aw) - 1;
    for (int m = 0; m < N; m++) begin acc[m] = 0; cnt[m] = 0; end
    for (int c = 0; c < nc; c++) begin
      if (stim_en[c]) begin
        for (int m = 0; m < N; m++) begin
          if (stim_val[c][m] && cnt[m] < BS) begin
            mag = (stim_res[c][m] < 0) ? -longint'(stim_res[c][m]) : longint'(stim_res[c][m]);
            if (!(WARM && cnt[m] <= m)) acc[m] = (acc[m] + mag > maxv) ? maxv : acc[m] + mag;
            cnt[m]++;
          end
        end
      end
    end
    best = 0;
    for (int m = 1; m < N; m++) if (acc[m] < acc[best]) best = m;
    e.order = 5'(best + 1);
    e.err   = 28'(acc[best]);
    return e;
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      stim_en[c] = 1'b1;
      for (int m = 0; m < N; m++) begin stim_val[c][m] = 1'b0; stim_res[c][m] = 0; end
    end
  endtask

  task automatic fill_const(input int c0, input int c1, input int r0, input int r1, input int r2, input int r3);
    for (int c = c0; c <= c1; c++) begin
      for (int m = 0; m < N; m++) stim_val[c][m] = 1'b1;
      stim_res[c][0] = r0; stim_res[c][1] = r1; stim_res[c][2] = r2; stim_res[c][3] = r3;
    end
  endtask

  task automatic feed(input int nc, input bit with_start);
    int cnt[N];
    int lastc;
    lastc = -1;
    for (int m = 0; m < N; m++) cnt[m] = 0;
    for (int c = 0; c < nc; c++)
      if (stim_en[c])
        for (int m = 0; m < N; m++)
          if (stim_val[c][m] && cnt[m] < BS) begin cnt[m]++; lastc = c; end
    if (with_start) begin
      en = 1'b1; start = 1'b1; val = '0;
      @(negedge clk);
      start = 1'b0;
    end
    for (int c = 0; c < nc; c++) begin
      en = stim_en[c];
      for (int m = 0; m < N; m++) begin
        val[m] = stim_val[c][m];
        res[m*RW +: RW] = RW'(stim_res[c][m]);
      end
      @(negedge clk);
      if (c == lastc) accept_cyc = cyc;
    end
    en = 1'b1; val = '0; res = '0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b0; val = '0; res = '0;
    repeat (3) @(negedge clk);
    total++; if (order_m !== 5'd1) begin bad++; $display("FAIL reset_order: got %0d required 1", order_m); end
    total++; if (err_m !== '0) begin bad++; $display("FAIL reset_error: got %0d required 0", err_m); end
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy_m); end
    total++; if (done_m !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done_m); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b required 0", busy_s); end
    $display("reset: order=%0d error=%0d busy=%b", order_m, err_m, busy_m);
  endtask

  task automatic test_basic();
    bit ok; int tgt;
    clear_stim(); fill_const(0, 7, 5, -3, 4, 7);
    q_m.push_back(WARM ? {5'd2, 28'd18} : {5'd2, 28'd24});
    q_s.push_back(WARM ? {5'd2, 28'd18} : {5'd2, 28'd24});
    tgt = done_cnt + 1;
    feed(8, 1'b1);
    total++; if (busy_m !== 1'b1) begin bad++; $display("FAIL basic_busy_accum: got %b required 1", busy_m); end
    wait_done(tgt, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: no oDone within bound"); end
    total++; if (done_cyc - accept_cyc !== N + 2) begin bad++; $display("FAIL basic_latency: got %0d edges required %0d", done_cyc - accept_cyc, N + 2); end
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL basic_busy_done: got %b required 0", busy_m); end
  endtask

  task automatic test_tie();
    bit ok; int tgt;
    clear_stim(); fill_const(0, 5, 4, 3, -3, 10); fill_const(6, 7, 3, 3, -3, 10);
    q_m.push_back(model(8, AW_M)); q_s.push_back(model(8, AW_S));
    tgt = done_cnt + 1;
    feed(8, 1'b1);
    wait_done(tgt, ok);
    total++; if (!ok) begin bad++; $display("FAIL tie_timeout: no oDone within bound"); end
  endtask

  task automatic test_stagger();
    bit ok; int tgt;
    clear_stim();
    for (int c = 0; c <= 10; c++) begin
      for (int m = 0; m < 3; m++) stim_val[c][m] = 1'b1;
      stim_res[c][0] = (c < 8) ? 5 : 100; stim_res[c][1] = (c < 8) ? -3 : 100; stim_res[c][2] = (c < 8) ? 4 : 100;
    end
    for (int c = 3; c <= 12; c++) begin stim_val[c][3] = 1'b1; stim_res[c][3] = (c <= 10) ? 7 : 100; end
    q_m.push_back(model(13, AW_M)); q_s.push_back(model(13, AW_S));
    tgt = done_cnt + 1;
    feed(13, 1'b1);
    wait_done(tgt, ok);
    total++; if (!ok) begin bad++; $display("FAIL stagger_timeout: no oDone within bound"); end
    total++; if (done_cyc - accept_cyc !== N + 2) begin bad++; $display("FAIL stagger_latency: got %0d edges required %0d", done_cyc - accept_cyc, N + 2); end
  endtask

  task automatic test_saturate();
    bit ok; int tgt;
    clear_stim(); fill_const(0, 7, -32768, -32768, -32768, -32768);
    q_m.push_back(WARM ? {5'd4, 28'd131072} : {5'd1, 28'd262144});
    q_s.push_back(WARM ? {5'd4, 28'd131072} : {5'd1, 28'd262143});
    tgt = done_cnt + 1;
    feed(8, 1'b1);
    wait_done(tgt, ok);
    total++; if (!ok) begin bad++; $display("FAIL saturate_timeout: no oDone within bound"); end
  endtask

  task automatic test_abort();
    bit ok; int tgt;
    clear_stim(); fill_const(0, 4, 1, 100, 100, 100);
    feed(5, 1'b1);
    clear_stim(); fill_const(0, 7, 5, -3, 4, 7);
    q_m.push_back(WARM ? {5'd2, 28'd18} : {5'd2, 28'd24});
    q_s.push_back(WARM ? {5'd2, 28'd18} : {5'd2, 28'd24});
    tgt = done_cnt + 1;
    feed(8, 1'b1);
    wait_done(tgt, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_timeout: no oDone within bound"); end
  endtask

  task automatic test_back_to_back();
    bit ok; int tgt;
    clear_stim(); fill_const(0, 7, 5, -3, 4, 7);
    q_m.push_back(model(8, AW_M)); q_s.push_back(model(8, AW_S));
    tgt = done_cnt + 2;
    feed(8, 1'b1);
    while (cyc < accept_cyc + N + 1) @(negedge clk);
    clear_stim(); fill_const(0, 5, 4, 3, -3, 10); fill_const(6, 7, 3, 3, -3, 10);
    q_m.push_back(model(8, AW_M)); q_s.push_back(model(8, AW_S));
    start = 1'b1; val = '0;
    @(negedge clk);
    start = 1'b0;
    total++; if (done_m !== 1'b1) begin bad++; $display("FAIL b2b_done_with_start: got %b required 1", done_m); end
    total++; if (busy_m !== 1'b1) begin bad++; $display("FAIL b2b_busy_after_start: got %b required 1", busy_m); end
    feed(8, 1'b0);
    wait_done(tgt, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: second oDone missing"); end
  endtask

  task automatic test_warmup();
    bit ok; int tgt;
    clear_stim(); fill_const(0, 7, 10, 10, 10, 10);
    q_m.push_back(WARM ? {5'd4, 28'd40} : {5'd1, 28'd80});
    q_s.push_back(WARM ? {5'd4, 28'd40} : {5'd1, 28'd80});
    tgt = done_cnt + 1;
    feed(8, 1'b1);
    wait_done(tgt, ok);
    total++; if (!ok) begin bad++; $display("FAIL warmup_timeout: no oDone within bound"); end
  endtask

  task automatic test_enable();
    bit ok; int tgt;
    clear_stim(); fill_const(0, 1, 5, -3, 4, 7); fill_const(2, 4, 50, 50, 50, 50); fill_const(5, 10, 5, -3, 4, 7);
    for (int c = 2; c <= 4; c++) stim_en[c] = 1'b0;
    q_m.push_back(model(11, AW_M)); q_s.push_back(model(11, AW_S));
    tgt = done_cnt + 1;
    feed(11, 1'b1);
    wait_done(tgt, ok);
    total++; if (!ok) begin bad++; $display("FAIL enable_timeout: no oDone within bound"); end
  endtask

  task automatic test_reset_mid_scan();
    clear_stim(); fill_const(0, 7, 1, 1, 1, 1);
    feed(8, 1'b1);
    repeat (2) @(negedge clk);
    total++; if (busy_m !== 1'b1) begin bad++; $display("FAIL midscan_busy: got %b required 1", busy_m); end
    rst = 1'b1;
    #1;
    total++; if (order_m !== 5'd1) begin bad++; $display("FAIL midscan_reset_order: got %0d required 1", order_m); end
    total++; if (err_m !== '0) begin bad++; $display("FAIL midscan_reset_error: got %0d required 0", err_m); end
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL midscan_reset_busy: got %b required 0", busy_m); end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    $display("reset mid-scan: order=%0d error=%0d busy=%b", order_m, err_m, busy_m);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_stagger();
    test_saturate();
    test_abort();
    test_back_to_back();
    test_warmup();
    test_enable();
    test_reset_mid_scan();
    total++; if (q_m.size() != 0) begin bad++; $display("FAIL pending_main: got %0d required 0", q_m.size()); end
    total++; if (q_s.size() != 0) begin bad++; $display("FAIL pending_sat: got %0d required 0", q_s.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
